// File: rtl/serial_feeder_pkg.sv
// Shared definitions for the serial byte feeder.
// Holds the default FIFO depth and histogram window size, the byte width,
// and the deserializer FSM state encoding.
package serial_feeder_pkg;

  localparam int DEPTH_DEF = 4;
  localparam int WIN_DEF   = 1024;
  localparam int BYTE_W    = 8;

  typedef enum logic [0:0] {
    UNSYNC = 1'b0,
    SHIFT  = 1'b1
  } fsm_state_e;

endpackage

// File: rtl/serial_byte_feeder_fifo.sv
// byte_fifo: small synchronous byte FIFO with pointer-based full/empty.
// Ports:
//   clk, nrst  - clock, asynchronous active-low reset (pointers only)
//   clr        - synchronous clear, empties the FIFO
//   push, din  - write request and data; ignored when full unless a pop
//                is accepted in the same cycle
//   pop, dout  - read request; dout always shows the current head
//   full/empty - occupancy flags
module byte_fifo
  import serial_feeder_pkg::*;
#(
  parameter int DEPTH = DEPTH_DEF
) (
  input  logic              clk,
  input  logic              nrst,
  input  logic              clr,
  input  logic              push,
  input  logic              pop,
  input  logic [BYTE_W-1:0] din,
  output logic [BYTE_W-1:0] dout,
  output logic              full,
  output logic              empty
);

  localparam int AW = $clog2(DEPTH);

  logic [BYTE_W-1:0] mem_r [DEPTH];
  logic [AW:0]       wr_ptr_r;
  logic [AW:0]       rd_ptr_r;
  logic              wr_en_s;
  logic              rd_en_s;

  // The extra pointer MSB distinguishes full from empty when the indexes match.
  assign empty   = (wr_ptr_r == rd_ptr_r);
  assign full    = (wr_ptr_r[AW-1:0] == rd_ptr_r[AW-1:0]) &&
                   (wr_ptr_r[AW] != rd_ptr_r[AW]);
  assign rd_en_s = pop && !empty;
  // A full FIFO still accepts a push when the head leaves in the same cycle.
  assign wr_en_s = push && (!full || rd_en_s);
  assign dout    = mem_r[rd_ptr_r[AW-1:0]];

  // Read and write pointers; clear returns both to zero.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      wr_ptr_r <= {(AW+1){1'b0}};
      rd_ptr_r <= {(AW+1){1'b0}};
    end else if (clr) begin
      wr_ptr_r <= {(AW+1){1'b0}};
      rd_ptr_r <= {(AW+1){1'b0}};
    end else begin
      if (wr_en_s) begin
        wr_ptr_r <= wr_ptr_r + (AW+1)'(1);
      end
      if (rd_en_s) begin
        rd_ptr_r <= rd_ptr_r + (AW+1)'(1);
      end
    end
  end

  // Storage array; contents are don't-care while the pointers say empty.
  always_ff @(posedge clk) begin
    if (wr_en_s && !clr) begin
      mem_r[wr_ptr_r[AW-1:0]] <= din;
    end
  end

endmodule

// File: rtl/serial_byte_feeder.sv
// serial_byte_feeder: deserializes an MSB-first bit stream into bytes,
// buffers them in a small FIFO and feeds a downstream histogram stage.
// Ports:
//   clk, nrst      - clock, asynchronous active-low reset
//   sin, sin_valid - serial bit and its qualifier
//   sync           - marks the qualified bit as bit 7 of a new byte
//   hold           - downstream stall, blocks emission
//   clr            - synchronous soft clear (highest priority)
//   write, data    - registered byte strobe and byte
//   win_cnt        - bytes emitted in the current window
//   win_done       - pulse with the WIN-th write of a window
//   overflow       - sticky: a byte was dropped on a full FIFO
module serial_byte_feeder
  import serial_feeder_pkg::*;
#(
  parameter int DEPTH = DEPTH_DEF,
  parameter int WIN   = WIN_DEF
) (
  input  logic                   clk,
  input  logic                   nrst,
  input  logic                   sin,
  input  logic                   sin_valid,
  input  logic                   sync,
  input  logic                   hold,
  input  logic                   clr,
  output logic                   write,
  output logic [BYTE_W-1:0]      data,
  output logic [$clog2(WIN)-1:0] win_cnt,
  output logic                   win_done,
  output logic                   overflow
);

  localparam int CW    = $clog2(BYTE_W);
  localparam int CNT_W = $clog2(WIN);

  fsm_state_e        state_r;
  fsm_state_e        state_nxt_s;
  logic [CW-1:0]     bit_cnt_r;
  logic [CW-1:0]     bit_cnt_nxt_s;
  logic [BYTE_W-1:0] shift_r;
  logic [BYTE_W-1:0] shift_nxt_s;
  logic [BYTE_W-1:0] byte_s;
  logic              push_s;
  logic              pop_s;
  logic              ovf_set_s;
  logic              fifo_full_s;
  logic              fifo_empty_s;
  logic [BYTE_W-1:0] fifo_dout_s;

  logic              write_r;
  logic [BYTE_W-1:0] data_r;
  logic [CNT_W-1:0]  win_cnt_r;
  logic              win_done_r;
  logic              overflow_r;

  // Deserializer state, bit count and shift register.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state_r   <= UNSYNC;
      bit_cnt_r <= {CW{1'b0}};
      shift_r   <= {BYTE_W{1'b0}};
    end else begin
      state_r   <= state_nxt_s;
      bit_cnt_r <= bit_cnt_nxt_s;
      shift_r   <= shift_nxt_s;
    end
  end

  // Deserializer next state: clr beats sync, sync beats normal shifting.
  always_comb begin
    state_nxt_s   = state_r;
    bit_cnt_nxt_s = bit_cnt_r;
    shift_nxt_s   = shift_r;
    push_s        = 1'b0;
    byte_s        = {shift_r[BYTE_W-2:0], sin};
    if (clr) begin
      state_nxt_s   = UNSYNC;
      bit_cnt_nxt_s = {CW{1'b0}};
      shift_nxt_s   = {BYTE_W{1'b0}};
    end else if (sync) begin
      state_nxt_s = SHIFT;
      if (sin_valid) begin
        // The sync bit lands in the LSB and reaches bit 7 after 7 more shifts.
        shift_nxt_s   = {{(BYTE_W-1){1'b0}}, sin};
        bit_cnt_nxt_s = CW'(1);
      end else begin
        shift_nxt_s   = {BYTE_W{1'b0}};
        bit_cnt_nxt_s = {CW{1'b0}};
      end
    end else begin
      case (state_r)
        UNSYNC: begin
          state_nxt_s = UNSYNC;
        end
        SHIFT: begin
          if (sin_valid) begin
            shift_nxt_s = byte_s;
            if (bit_cnt_r == CW'(BYTE_W-1)) begin
              push_s        = 1'b1;
              bit_cnt_nxt_s = {CW{1'b0}};
            end else begin
              bit_cnt_nxt_s = bit_cnt_r + CW'(1);
            end
          end else begin
            bit_cnt_nxt_s = bit_cnt_r;
          end
        end
        default: begin
          state_nxt_s   = UNSYNC;
          bit_cnt_nxt_s = {CW{1'b0}};
          shift_nxt_s   = {BYTE_W{1'b0}};
        end
      endcase
    end
  end

  // A pop only ever sees bytes already stored, so an empty FIFO never bypasses.
  assign pop_s     = !fifo_empty_s && !hold && !clr;
  assign ovf_set_s = push_s && fifo_full_s && !pop_s;

  byte_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .nrst  (nrst),
    .clr   (clr),
    .push  (push_s),
    .pop   (pop_s),
    .din   (byte_s),
    .dout  (fifo_dout_s),
    .full  (fifo_full_s),
    .empty (fifo_empty_s)
  );

  // Output register, window counter and sticky overflow; data survives clr.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      write_r    <= 1'b0;
      data_r     <= {BYTE_W{1'b0}};
      win_cnt_r  <= {CNT_W{1'b0}};
      win_done_r <= 1'b0;
      overflow_r <= 1'b0;
    end else if (clr) begin
      write_r    <= 1'b0;
      win_cnt_r  <= {CNT_W{1'b0}};
      win_done_r <= 1'b0;
      overflow_r <= 1'b0;
    end else begin
      write_r    <= pop_s;
      win_done_r <= pop_s && (win_cnt_r == CNT_W'(WIN-1));
      if (pop_s) begin
        data_r    <= fifo_dout_s;
        win_cnt_r <= win_cnt_r + CNT_W'(1);
      end
      if (ovf_set_s) begin
        overflow_r <= 1'b1;
      end
    end
  end

  assign write    = write_r;
  assign data     = data_r;
  assign win_cnt  = win_cnt_r;
  assign win_done = win_done_r;
  assign overflow = overflow_r;

endmodule

// File: tb/tb_serial_byte_feeder.sv
module tb_serial_byte_feeder;

  logic       clk = 1'b0;
  logic       nrst;
  logic       sin;
  logic       sin_valid;
  logic       sync;
  logic       hold;
  logic       clr;
  logic       write;
  logic [7:0] data;
  logic [9:0] win_cnt;
  logic       win_done;
  logic       overflow;

  int vec  = 0;
  int errs = 0;
  int cyc  = 0;

  // Write monitor state, updated only by the monitor process.
  logic [7:0] wr_q[$];
  int         wr_t[$];
  int         wr_total = 0;
  int         done_cnt = 0;
  int         done_idx = 0;
  int         done_wc  = 0;

  serial_byte_feeder dut (
    .clk       (clk),
    .nrst      (nrst),
    .sin       (sin),
    .sin_valid (sin_valid),
    .sync      (sync),
    .hold      (hold),
    .clr       (clr),
    .write     (write),
    .data      (data),
    .win_cnt   (win_cnt),
    .win_done  (win_done),
    .overflow  (overflow)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (write === 1'b1) begin
      wr_q.push_back(data);
      wr_t.push_back(cyc);
      wr_total <= wr_total + 1;
    end
    if (win_done === 1'b1) begin
      done_cnt <= done_cnt + 1;
      done_idx <= wr_total + 1;
      done_wc  <= int'(win_cnt);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_bits(input logic [7:0] v, input int n, input bit with_sync);
    for (int i = 0; i < n; i++) begin
      sin       = v[7-i];
      sin_valid = 1'b1;
      sync      = with_sync && (i == 0);
      tick();
    end
    sin       = 1'b0;
    sin_valid = 1'b0;
    sync      = 1'b0;
  endtask

  task automatic do_clr();
    clr = 1'b1;
    tick();
    clr = 1'b0;
  endtask

  task automatic test_reset();
    nrst = 1'b0; sin = 1'b0; sin_valid = 1'b0; sync = 1'b0; hold = 1'b0; clr = 1'b0;
    #3;
    vec++; if (write !== 1'b0) begin errs++; $display("FAIL reset_write got %b exp 0", write); end
    vec++; if (data !== 8'h00) begin errs++; $display("FAIL reset_data got %h exp 00", data); end
    vec++; if (win_cnt !== 10'd0) begin errs++; $display("FAIL reset_win_cnt got %0d exp 0", win_cnt); end
    vec++; if (overflow !== 1'b0) begin errs++; $display("FAIL reset_overflow got %b exp 0", overflow); end
    repeat (2) tick();
    nrst = 1'b1;
    repeat (2) tick();
  endtask

  task automatic test_basic();
    wr_q.delete(); wr_t.delete();
    send_bits(8'hA5, 8, 1'b1);
    vec++; if (write !== 1'b0) begin errs++; $display("FAIL basic_early_write got %b exp 0", write); end
    tick();
    vec++; if (write !== 1'b1) begin errs++; $display("FAIL basic_write got %b exp 1", write); end
    vec++; if (data !== 8'hA5) begin errs++; $display("FAIL basic_data got %h exp a5", data); end
    vec++; if (overflow !== 1'b0) begin errs++; $display("FAIL basic_overflow got %b exp 0", overflow); end
    tick();
    vec++; if (write !== 1'b0) begin errs++; $display("FAIL basic_write_drop got %b exp 0", write); end
  endtask

  task automatic test_presync();
    do_clr();
    wr_q.delete(); wr_t.delete();
    send_bits(8'hFF, 8, 1'b0);
    repeat (4) tick();
    vec++; if (wr_q.size() != 0) begin errs++; $display("FAIL presync_writes got %0d exp 0", wr_q.size()); end
    send_bits(8'hE0, 3, 1'b1);
    send_bits(8'h3C, 8, 1'b1);
    repeat (4) tick();
    vec++; if (wr_q.size() != 1) begin errs++; $display("FAIL resync_count got %0d exp 1", wr_q.size()); end
    else begin
      vec++; if (wr_q[0] !== 8'h3C) begin errs++; $display("FAIL resync_data got %h exp 3c", wr_q[0]); end
    end
  endtask

  task automatic test_overflow();
    wr_q.delete(); wr_t.delete();
    hold = 1'b1;
    for (int k = 1; k <= 6; k++) send_bits(8'(k), 8, 1'b1);
    repeat (2) tick();
    vec++; if (wr_q.size() != 0) begin errs++; $display("FAIL hold_writes got %0d exp 0", wr_q.size()); end
    vec++; if (overflow !== 1'b1) begin errs++; $display("FAIL ovf_set got %b exp 1", overflow); end
    hold = 1'b0;
    repeat (6) tick();
    vec++; if (wr_q.size() != 4) begin errs++; $display("FAIL drain_count got %0d exp 4", wr_q.size()); end
    else begin
      for (int i = 0; i < 4; i++) begin
        vec++; if (wr_q[i] !== 8'(i + 1)) begin errs++; $display("FAIL drain_data[%0d] got %h exp %h", i, wr_q[i], 8'(i + 1)); end
        vec++; if (wr_t[i] != wr_t[0] + i) begin errs++; $display("FAIL drain_cycle[%0d] got %0d exp %0d", i, wr_t[i], wr_t[0] + i); end
      end
    end
    vec++; if (overflow !== 1'b1) begin errs++; $display("FAIL ovf_sticky got %b exp 1", overflow); end
    do_clr();
    vec++; if (overflow !== 1'b0) begin errs++; $display("FAIL ovf_clr got %b exp 0", overflow); end
  endtask

  task automatic test_full_pushpop();
    logic [7:0] last;
    wr_q.delete(); wr_t.delete();
    hold = 1'b1;
    for (int k = 0; k < 4; k++) send_bits(8'(8'h10 + k), 8, 1'b1);
    last = 8'h14;
    send_bits(last, 7, 1'b1);
    sin = last[0]; sin_valid = 1'b1; hold = 1'b0;
    tick();
    sin_valid = 1'b0;
    vec++; if (overflow !== 1'b0) begin errs++; $display("FAIL pushpop_ovf got %b exp 0", overflow); end
    repeat (8) tick();
    vec++; if (wr_q.size() != 5) begin errs++; $display("FAIL pushpop_count got %0d exp 5", wr_q.size()); end
    else begin
      for (int i = 0; i < 5; i++) begin
        vec++; if (wr_q[i] !== 8'(8'h10 + i)) begin errs++; $display("FAIL pushpop_data[%0d] got %h exp %h", i, wr_q[i], 8'(8'h10 + i)); end
      end
    end
    vec++; if (overflow !== 1'b0) begin errs++; $display("FAIL pushpop_ovf_end got %b exp 0", overflow); end
  endtask

  task automatic test_window();
    int base_total;
    int base_done;
    do_clr();
    wr_q.delete(); wr_t.delete();
    base_total = wr_total;
    base_done  = done_cnt;
    for (int n = 0; n < 1024; n++) send_bits(8'(n), 8, 1'b1);
    repeat (4) tick();
    vec++; if (wr_q.size() != 1024) begin errs++; $display("FAIL win_writes got %0d exp 1024", wr_q.size()); end
    else begin
      vec++; if (wr_q[1023] !== 8'hFF) begin errs++; $display("FAIL win_last_data got %h exp ff", wr_q[1023]); end
    end
    vec++; if (done_cnt - base_done != 1) begin errs++; $display("FAIL win_done_count got %0d exp 1", done_cnt - base_done); end
    vec++; if (done_idx != base_total + 1024) begin errs++; $display("FAIL win_done_index got %0d exp %0d", done_idx - base_total, 1024); end
    vec++; if (done_wc != 0) begin errs++; $display("FAIL win_cnt_at_done got %0d exp 0", done_wc); end
    vec++; if (win_cnt !== 10'd0) begin errs++; $display("FAIL win_cnt_after got %0d exp 0", win_cnt); end
    send_bits(8'h5A, 8, 1'b1);
    repeat (3) tick();
    vec++; if (win_cnt !== 10'd1) begin errs++; $display("FAIL win_cnt_1025 got %0d exp 1", win_cnt); end
    vec++; if (data !== 8'h5A) begin errs++; $display("FAIL win_data_1025 got %h exp 5a", data); end
    vec++; if (done_cnt - base_done != 1) begin errs++; $display("FAIL win_done_extra got %0d exp 1", done_cnt - base_done); end
  endtask

  task automatic test_reset_mid();
    hold = 1'b1;
    for (int k = 0; k < 3; k++) send_bits(8'(8'h21 + k), 8, 1'b1);
    send_bits(8'h24, 4, 1'b1);
    #2;
    nrst = 1'b0;
    #1;
    vec++; if (write !== 1'b0) begin errs++; $display("FAIL midrst_write got %b exp 0", write); end
    vec++; if (data !== 8'h00) begin errs++; $display("FAIL midrst_data got %h exp 00", data); end
    vec++; if (win_cnt !== 10'd0) begin errs++; $display("FAIL midrst_win_cnt got %0d exp 0", win_cnt); end
    vec++; if (win_done !== 1'b0) begin errs++; $display("FAIL midrst_win_done got %b exp 0", win_done); end
    vec++; if (overflow !== 1'b0) begin errs++; $display("FAIL midrst_overflow got %b exp 0", overflow); end
    tick();
    nrst = 1'b1;
    hold = 1'b0;
    wr_q.delete(); wr_t.delete();
    repeat (4) tick();
    send_bits(8'hFF, 8, 1'b0);
    repeat (4) tick();
    vec++; if (wr_q.size() != 0) begin errs++; $display("FAIL midrst_spurious got %0d exp 0", wr_q.size()); end
  endtask

  task automatic test_clr();
    wr_q.delete(); wr_t.delete();
    send_bits(8'h77, 8, 1'b1);
    repeat (3) tick();
    hold = 1'b1;
    for (int k = 0; k < 5; k++) send_bits(8'(8'h31 + k), 8, 1'b1);
    send_bits(8'h36, 3, 1'b1);
    vec++; if (overflow !== 1'b1) begin errs++; $display("FAIL clr_pre_ovf got %b exp 1", overflow); end
    wr_q.delete(); wr_t.delete();
    clr = 1'b1; hold = 1'b0;
    tick();
    clr = 1'b0;
    vec++; if (write !== 1'b0) begin errs++; $display("FAIL clr_write got %b exp 0", write); end
    vec++; if (win_done !== 1'b0) begin errs++; $display("FAIL clr_win_done got %b exp 0", win_done); end
    vec++; if (win_cnt !== 10'd0) begin errs++; $display("FAIL clr_win_cnt got %0d exp 0", win_cnt); end
    vec++; if (overflow !== 1'b0) begin errs++; $display("FAIL clr_overflow got %b exp 0", overflow); end
    vec++; if (data !== 8'h77) begin errs++; $display("FAIL clr_data_kept got %h exp 77", data); end
    repeat (6) tick();
    send_bits(8'hFF, 8, 1'b0);
    repeat (4) tick();
    vec++; if (wr_q.size() != 0) begin errs++; $display("FAIL clr_spurious got %0d exp 0", wr_q.size()); end
    send_bits(8'hC3, 8, 1'b1);
    repeat (3) tick();
    vec++; if (wr_q.size() != 1) begin errs++; $display("FAIL clr_resume_count got %0d exp 1", wr_q.size()); end
    else begin
      vec++; if (wr_q[0] !== 8'hC3) begin errs++; $display("FAIL clr_resume_data got %h exp c3", wr_q[0]); end
    end
    vec++; if (win_cnt !== 10'd1) begin errs++; $display("FAIL clr_resume_cnt got %0d exp 1", win_cnt); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_presync();
    test_overflow();
    test_full_pushpop();
    test_window();
    test_reset_mid();
    test_clr();
    $display("== %0d vectors applied, %0d miscompares ==", vec, errs);
    $finish;
  end

endmodule
